// File: rtl/cory_arb4_wrr.sv
// -----------------------------------------------------------------------------
// cory_arb4_wrr
//
// Four-input weighted round-robin arbiter with per-requester credit counters.
// One valid/ready downstream channel is shared by four requesters. Beats are
// delivered in proportion to each requester's weight. A requester with weight
// wt receives wt+1 beats per round. A single registered output stage carries
// the data beat and the 2-bit id of the requester that sent it.
//
// Parameters:
//   N  - data width
//   B  - weight width (credit per round is wt+1, i.e. 1..2^B beats)
//
// Ports:
//   clk        clock
//   reset_n    asynchronous, active-low reset
//   i_aK_v     requester K valid (K = 0..3)
//   i_aK_d     requester K data
//   i_aK_wt    requester K weight, sampled only when credits are refilled
//   o_aK_r     requester K ready (at most one asserted per cycle)
//   o_z_v      output valid
//   o_z_d      output data
//   o_z_s      source id of o_z_d
//   i_z_r      output ready
//
// Optional build macro:
//   CORY_ARB4_WRR_STRICT0_EN - when defined, requester 0 has strict priority
//   over the others and takes no part in credit accounting. Its weight input
//   is ignored. When undefined, all four requesters share the WRR scheme.
// -----------------------------------------------------------------------------
module cory_arb4_wrr #(
    parameter int N = 8,
    parameter int B = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_a0_v,
    input  logic [N-1:0] i_a0_d,
    input  logic [B-1:0] i_a0_wt,
    output logic         o_a0_r,
    input  logic         i_a1_v,
    input  logic [N-1:0] i_a1_d,
    input  logic [B-1:0] i_a1_wt,
    output logic         o_a1_r,
    input  logic         i_a2_v,
    input  logic [N-1:0] i_a2_d,
    input  logic [B-1:0] i_a2_wt,
    output logic         o_a2_r,
    input  logic         i_a3_v,
    input  logic [N-1:0] i_a3_d,
    input  logic [B-1:0] i_a3_wt,
    output logic         o_a3_r,
    output logic         o_z_v,
    output logic [N-1:0] o_z_d,
    output logic [1:0]   o_z_s,
    input  logic         i_z_r
);

    localparam logic [B:0] ONE = {{B{1'b0}}, 1'b1};

    // Requesters that take part in credit accounting. Under strict priority
    // requester 0 bypasses credits entirely, so it must not hold off a refill.
`ifdef CORY_ARB4_WRR_STRICT0_EN
    localparam logic [3:0] WRR_MASK = 4'b1110;
`else
    localparam logic [3:0] WRR_MASK = 4'b1111;
`endif

    logic [3:0]   req_v;
    logic [N-1:0] req_d  [4];
    logic [B-1:0] req_wt [4];

    logic [B:0]   cnt  [4];
    logic [B:0]   ecnt [4];
    logic [1:0]   ptr;

    logic [3:0]   elig;
    logic         any_v;
    logic         refill;
    logic [1:0]   wrr_g;
    logic         strict_win;
    logic [1:0]   g;
    logic [B:0]   g_left;
    logic         load;
    logic         accept;

    assign req_v     = {i_a3_v, i_a2_v, i_a1_v, i_a0_v};
    assign req_d[0]  = i_a0_d;
    assign req_d[1]  = i_a1_d;
    assign req_d[2]  = i_a2_d;
    assign req_d[3]  = i_a3_d;
    assign req_wt[0] = i_a0_wt;
    assign req_wt[1] = i_a1_wt;
    assign req_wt[2] = i_a2_wt;
    assign req_wt[3] = i_a3_wt;

    // A requester is eligible when it is asking and still has credit left
    // from the current round.
    always_comb begin
        elig = '0;
        for (int k = 0; k < 4; k++) begin
            elig[k] = req_v[k] & WRR_MASK[k] & (cnt[k] != '0);
        end
    end

    assign any_v  = |req_v;
    // Idle requesters keep their credit and do not block a refill; a new
    // round starts only when every asking requester has run dry.
    assign refill = (|(req_v & WRR_MASK)) & ~(|elig);

    // Effective credit: the refill is applied combinationally so the first
    // beat of a new round goes out in the same cycle, without a bubble.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            ecnt[k] = cnt[k];
            if (refill && WRR_MASK[k]) begin
                ecnt[k] = {1'b0, req_wt[k]} + ONE;
            end
        end
    end

    // Rotating search for the first asking requester with credit, starting
    // at the round-robin pointer.
    always_comb begin
        logic       hit;
        logic [1:0] cand;
        hit   = 1'b0;
        cand  = ptr;
        wrr_g = ptr;
        for (int i = 0; i < 4; i++) begin
            cand = ptr + 2'(i);
            if (!hit && req_v[cand] && WRR_MASK[cand] && (ecnt[cand] != '0)) begin
                wrr_g = cand;
                hit   = 1'b1;
            end
        end
    end

`ifdef CORY_ARB4_WRR_STRICT0_EN
    assign strict_win = req_v[0];
`else
    assign strict_win = 1'b0;
`endif

    assign g      = strict_win ? 2'd0 : wrr_g;
    assign g_left = ecnt[g] - ONE;

    // One-entry pipe: a new beat may enter whenever the stage is empty or
    // its current beat leaves this cycle.
    assign load   = ~o_z_v | i_z_r;
    assign accept = load & any_v;

    assign o_a0_r = accept & (g == 2'd0);
    assign o_a1_r = accept & (g == 2'd1);
    assign o_a2_r = accept & (g == 2'd2);
    assign o_a3_r = accept & (g == 2'd3);

    // Credit and pointer update. The granted requester pays one credit and
    // all others take their effective credit, which commits a pending refill.
    // The pointer stays on the granted requester while its burst lasts.
    // A strict-priority win leaves the pointer untouched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= '0;
            end
            ptr <= 2'd0;
        end else if (accept) begin
            for (int k = 0; k < 4; k++) begin
                cnt[k] <= (!strict_win && (2'(k) == g)) ? g_left : ecnt[k];
            end
            if (!strict_win) begin
                ptr <= (g_left != '0) ? g : g + 2'd1;
            end
        end
    end

    // Registered output stage. Data and source hold while a beat is stalled
    // and also when the stage drains to empty.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_z_v <= 1'b0;
            o_z_s <= 2'd0;
            o_z_d <= '0;
        end else if (load) begin
            if (any_v) begin
                o_z_v <= 1'b1;
                o_z_s <= g;
                o_z_d <= req_d[g];
            end else begin
                o_z_v <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cory_arb4_wrr.sv
// -----------------------------------------------------------------------------
// tb_cory_arb4_wrr
//
// Self-checking bench for cory_arb4_wrr. A behavioural model tracks credits as
// integers, performs the rotating search arithmetically, and predicts the
// output register and the ready lines each cycle. Directed scenarios also
// check fixed grant sequences worked out by hand.
// -----------------------------------------------------------------------------
module tb_cory_arb4_wrr;

`ifdef CORY_ARB4_WRR_STRICT0_EN
    localparam bit STRICT = 1'b1;
`else
    localparam bit STRICT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] a_v = '0;
    logic [7:0] a_d  [4];
    logic [3:0] a_wt [4];
    logic       z_r = 1'b0;
    logic       a0_r, a1_r, a2_r, a3_r;
    logic       z_v;
    logic [1:0] z_s;
    logic [7:0] z_d;

    int n_tests = 0;
    int n_fail  = 0;

    // model state
    int         m_cnt  [4];
    int         m_ecnt [4];
    int         m_ptr;
    int         m_g;
    bit         m_gv, m_load, m_win;
    logic       m_v;
    logic [1:0] m_s;
    logic [7:0] m_d;
    logic [3:0] m_rdy;

    cory_arb4_wrr #(.N(8), .B(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .i_a0_v  (a_v[0]), .i_a0_d (a_d[0]), .i_a0_wt (a_wt[0]), .o_a0_r (a0_r),
        .i_a1_v  (a_v[1]), .i_a1_d (a_d[1]), .i_a1_wt (a_wt[1]), .o_a1_r (a1_r),
        .i_a2_v  (a_v[2]), .i_a2_d (a_d[2]), .i_a2_wt (a_wt[2]), .o_a2_r (a2_r),
        .i_a3_v  (a_v[3]), .i_a3_d (a_d[3]), .i_a3_wt (a_wt[3]), .o_a3_r (a3_r),
        .o_z_v   (z_v),
        .o_z_d   (z_d),
        .o_z_s   (z_s),
        .i_z_r   (z_r)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] act_vec();
        return {z_v, z_s, z_d, a3_r, a2_r, a1_r, a0_r};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {m_v, m_s, m_d, m_rdy};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
        m_ptr = 0;
        m_v   = 1'b0;
        m_s   = 2'd0;
        m_d   = 8'd0;
    endtask

    // Predict this cycle's grant and ready lines from the current inputs.
    task automatic model_eval();
        bit wrr_any, has_credit;
        wrr_any    = 1'b0;
        has_credit = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!(STRICT && k == 0) && a_v[k]) begin
                wrr_any = 1'b1;
                if (m_cnt[k] > 0) has_credit = 1'b1;
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (wrr_any && !has_credit && !(STRICT && k == 0))
                m_ecnt[k] = int'(a_wt[k]) + 1;
            else
                m_ecnt[k] = m_cnt[k];
        end
        m_gv  = (a_v != 4'b0);
        m_win = STRICT && a_v[0];
        m_g   = 0;
        if (!m_win) begin
            for (int i = 0; i < 4; i++) begin
                int k;
                k = (m_ptr + i) % 4;
                if (!(STRICT && k == 0) && a_v[k] && m_ecnt[k] > 0) begin
                    m_g = k;
                    break;
                end
            end
        end
        m_load = !m_v || z_r;
        m_rdy  = (m_load && m_gv) ? 4'(1 << m_g) : 4'b0;
    endtask

    // Apply one clock edge to the model.
    task automatic model_clock();
        if (m_load) begin
            if (m_gv) begin
                m_v = 1'b1;
                m_s = 2'(m_g);
                m_d = a_d[m_g];
                for (int k = 0; k < 4; k++) m_cnt[k] = m_ecnt[k];
                if (!m_win) begin
                    m_cnt[m_g] = m_ecnt[m_g] - 1;
                    m_ptr = (m_cnt[m_g] != 0) ? m_g : (m_g + 1) % 4;
                end
            end else begin
                m_v = 1'b0;
            end
        end
    endtask

    task automatic advance();
        model_eval();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_v     = '0;
        z_r     = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_d[k]  = 8'd0;
            a_wt[k] = 4'd0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        model_eval();
        n_tests++;
        if ({z_v, z_s, z_d} !== 11'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %h want %h", {z_v, z_s, z_d}, 11'd0);
        end
        n_tests++;
        if (act_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL reset_model: got %h want %h", act_vec(), exp_vec());
        end
        advance();
    endtask

    task automatic test_weight_sequence();
        int pat [10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'(k);
        a_v = 4'hF;
        z_r = 1'b1;
        for (int c = 0; c < 31; c++) begin
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL wrr_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (!STRICT && c >= 1) begin
                n_tests++;
                if ({z_v, z_s} !== {1'b1, 2'(pat[(c - 1) % 10])}) begin
                    n_fail++;
                    $display("[TB] FAIL wrr_sequence cyc %0d: got v=%b s=%0d want v=1 s=%0d",
                             c, z_v, z_s, pat[(c - 1) % 10]);
                end
            end
            advance();
        end
    endtask

    task automatic test_single_requester();
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'($urandom);
        a_wt[2] = 4'd0;
        a_v     = 4'b0100;
        z_r     = 1'b1;
        for (int c = 0; c < 12; c++) begin
            a_d[2] = 8'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL single_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            n_tests++;
            if ({a3_r, a2_r, a1_r, a0_r} !== 4'b0100) begin
                n_fail++;
                $display("[TB] FAIL single_ready cyc %0d: got %b want 0100", c, {a3_r, a2_r, a1_r, a0_r});
            end
            if (c >= 1) begin
                n_tests++;
                if ({z_v, z_s} !== 3'b110) begin
                    n_fail++;
                    $display("[TB] FAIL single_out cyc %0d: got v=%b s=%0d want v=1 s=2", c, z_v, z_s);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        int hs[$];
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'd3;
        a_v = 4'hF;
        for (int c = 0; c < 30; c++) begin
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            z_r = !(c >= 6 && c <= 10);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL stall_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (!z_r) begin
                n_tests++;
                if ({z_v, a3_r, a2_r, a1_r, a0_r} !== 5'b10000) begin
                    n_fail++;
                    $display("[TB] FAIL stall_ready cyc %0d: got %b want 10000",
                             c, {z_v, a3_r, a2_r, a1_r, a0_r});
                end
            end
            if (z_v && z_r) hs.push_back(int'(z_s));
            advance();
        end
        n_tests++;
        if (hs.size() != 24) begin
            n_fail++;
            $display("[TB] FAIL stall_beats: got %0d want 24", hs.size());
        end
        if (!STRICT) begin
            foreach (hs[i]) begin
                n_tests++;
                if (hs[i] != (i / 4) % 4) begin
                    n_fail++;
                    $display("[TB] FAIL stall_order beat %0d: got %0d want %0d", i, hs[i], (i / 4) % 4);
                end
            end
        end
    endtask

    task automatic test_idle_credit();
        int gexp [20] = '{0, 0, 0, 0, 1, 2, 2, 2, 2, 3, 3, 3, 3, 1, 1, 1, 2, 2, 2, 2};
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'd3;
        z_r = 1'b1;
        for (int c = 0; c < 22; c++) begin
            a_v = (c >= 5 && c <= 8) ? 4'b1101 : 4'b1111;
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL idle_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (!STRICT && c >= 1 && c <= 20) begin
                n_tests++;
                if ({z_v, z_s} !== {1'b1, 2'(gexp[c - 1])}) begin
                    n_fail++;
                    $display("[TB] FAIL idle_sequence cyc %0d: got v=%b s=%0d want v=1 s=%0d",
                             c, z_v, z_s, gexp[c - 1]);
                end
            end
            advance();
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'($urandom);
        a_v = 4'hF;
        z_r = 1'b1;
        for (int c = 0; c < 6; c++) begin
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL midrst_pre cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            advance();
        end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        n_tests++;
        if ({z_v, z_s, z_d} !== 11'd0) begin
            n_fail++;
            $display("[TB] FAIL midrst_clear: got %h want %h", {z_v, z_s, z_d}, 11'd0);
        end
        for (int k = 0; k < 4; k++) a_wt[k] = 4'($urandom);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL midrst_post cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (c == 1) begin
                n_tests++;
                if ({z_v, z_s} !== 3'b100) begin
                    n_fail++;
                    $display("[TB] FAIL midrst_first: got v=%b s=%0d want v=1 s=0", z_v, z_s);
                end
            end
            advance();
        end
    endtask

    task automatic test_strict();
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'd0;
        z_r = 1'b1;
        for (int c = 0; c < 20; c++) begin
            a_v = (c % 2 == 0) ? 4'b1111 : 4'b1110;
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL strict_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            if (STRICT && c >= 1) begin
                int want;
                want = ((c - 1) % 2 == 0) ? 0 : ((c - 2) / 2) % 3 + 1;
                n_tests++;
                if ({z_v, z_s} !== {1'b1, 2'(want)}) begin
                    n_fail++;
                    $display("[TB] FAIL strict_sequence cyc %0d: got v=%b s=%0d want v=1 s=%0d",
                             c, z_v, z_s, want);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 4; k++) a_wt[k] = 4'($urandom);
        for (int c = 0; c < 400; c++) begin
            a_v = 4'($urandom) | 4'($urandom);
            for (int k = 0; k < 4; k++) a_d[k] = 8'($urandom);
            if (c % 37 == 0) begin
                for (int k = 0; k < 4; k++) a_wt[k] = 4'($urandom);
            end
            z_r = ($urandom_range(0, 3) != 0);
            #1;
            model_eval();
            n_tests++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random_model cyc %0d: got %h want %h", c, act_vec(), exp_vec());
            end
            advance();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            a_d[k]  = 8'd0;
            a_wt[k] = 4'd0;
        end
        model_reset();
        test_reset();
        test_weight_sequence();
        test_single_requester();
        test_backpressure();
        test_idle_credit();
        test_reset_midburst();
        test_strict();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cory_arb4_wrr.md
Name: cory_arb4_wrr

Overview:
Four-input weighted round-robin arbiter with per-requester credit counters. It shares one valid/ready downstream channel among four requesters and delivers beats in proportion to per-requester weights. A single registered output stage carries data plus a 2-bit source id. Used in front of shared bus/memory ports where the 2-input bandwidth arbiter is insufficient.

Parameters:
N, 8, data width
B, 4, weight width; credit per round = wt+1 beats (1..2^B)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous, active-low reset
i_aK_v  input  1  requester K valid (K=0..3)
i_aK_d  input  N  requester K data
i_aK_wt  input  B  requester K weight; 0 means 1 beat per round
o_aK_r  output  1  requester K ready
o_z_v  output  1  output valid
o_z_d  output  N  output data
o_z_s  output  2  source id of o_z_d
i_z_r  input  1  output ready

Behaviour:
- State: cnt_K[B:0] credit per requester; ptr[1:0] round-robin start pointer; output register {o_z_v, o_z_s, o_z_d}.
- Reset: cnt_K=0, ptr=0, o_z_v=0, o_z_s=0, o_z_d=0. Reset mid-transfer drops the held beat; no partial state survives.
- load = !o_z_v | i_z_r (one-entry pipe; full throughput when i_z_r=1).
- any_v = OR of i_aK_v. elig_K = i_aK_v & (cnt_K!=0).
- refill = any_v & no elig_K. Effective credit ecnt_K = refill ? i_aK_wt+1 : cnt_K. Refill is combinational in the same cycle, so there is no bubble.
- Grant g = first K with i_aK_v & ecnt_K!=0, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4). gv = any_v.
- o_aK_r = load & gv & (g==K). All other ready signals are 0. o_aK_r does not depend on i_aK_v of non-granted requesters beyond the search.
- On accept (load & gv): o_z_v<=1, o_z_d<=i_ag_d, o_z_s<=g.
  - cnt_g <= ecnt_g-1. Every other cnt_K <= ecnt_K, so a refill is committed.
  - ptr <= (ecnt_g-1 != 0) ? g : g+1 (burst continues on the same requester until its credit is exhausted).
- load & !gv: o_z_v<=0; cnt and ptr unchanged.
- !load: everything holds; o_z_d/o_z_s stable while o_z_v & !i_z_r.
- Credits persist while a requester is idle. An idle requester does not block refill; refill occurs only when every valid requester has zero credit.
- Weight change takes effect at the next refill only.
- Latency: 1 cycle, input accept to o_z_v.

Optional Feature:
CORY_ARB4_WRR_STRICT0_EN
- Defined: requester 0 is strict priority. Whenever i_a0_v=1 it wins (g=0) regardless of credit. cnt_0 and ptr are unchanged, and requester 0 is excluded from elig/refill. i_a0_wt is ignored.
- Undefined: requester 0 is an ordinary WRR participant as above.

Test Plan:
- wt={0,1,2,3}, all valid continuously, i_z_r=1 -> o_z_s repeats 0,1,1,2,2,2,3,3,3,3 with o_z_v=1 every cycle after the first, no bubbles.
- Only a2 valid, wt2=0 -> one beat per cycle, refill every cycle, o_z_s=2 constantly, o_a2_r=1.
- All valid, wt={3,3,3,3}, i_z_r held 0 for 5 cycles mid-burst -> o_z_v/o_z_d/o_z_s stable, all o_aK_r=0; sequence resumes with no lost or duplicated beat.
- a1 drops valid after 1 of 4 credited beats, others continue -> a1 keeps 3 credits; on its return it is served when ptr reaches it, before any refill.
- Assert reset_n mid-burst with o_z_v=1 -> o_z_v=0 immediately; after release the first grant is requester 0 with fresh weights.
- STRICT0_EN defined, a0 valid on alternate cycles, a1..a3 valid with wt=0 -> a0 beats appear whenever valid; a1..a3 interleave 1,2,3 in the remaining slots.
